// File: rtl/up_down_counter_n_if.sv
// rtl/up_down_counter_n_if.sv - control and count bundle for up_down_counter_n
interface up_down_counter_n_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             carry;
    logic             tc;

    modport master (
        output en, up, load, load_val,
        input  q, carry, tc
    );

    modport slave (
        input  en, up, load, load_val,
        output q, carry, tc
    );
endinterface

// File: rtl/up_down_counter_n.sv
// rtl/up_down_counter_n.sv - registered N-bit up/down counter with wrap or saturate policy
module up_down_counter_n #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    up_down_counter_n_if.slave  bus
);
    logic [WIDTH-1:0] q_r;
    logic             carry_r;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   chain;
    logic             boundary;

    // Half-adder ripple: counting up propagates through 1 bits, counting down
    // borrows through 0 bits, so the chain output flags the wrap/underflow step.
    assign chain[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign sum[i]     = q_r[i] ^ chain[i];
        assign chain[i+1] = (bus.up ? q_r[i] : ~q_r[i]) & chain[i];
    end

    assign boundary = chain[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            q_r     <= '0;
            carry_r <= 1'b0;
        end else if (bus.load) begin
            q_r     <= bus.load_val;
            carry_r <= 1'b0;
        end else if (bus.en) begin
            carry_r <= boundary;
            if (!(boundary && SATURATE)) begin
                q_r <= sum;
            end
        end else begin
            carry_r <= 1'b0;
        end
    end

    assign bus.q     = q_r;
    assign bus.carry = carry_r;
    assign bus.tc    = bus.up ? (&q_r) : ~(|q_r);
endmodule
